dist_scheduler: RTL and testbench
=================================

Name: dist_scheduler

Overview:
- Sequencing controller for the 8-bit 1-to-2 data distributor datapath.
- Accepts a valid/ready input byte stream and holds each byte in a one-entry register.
- Chooses the destination channel by round-robin or by a per-word destination bit.
- Drives the distributor enable/select and presents the byte on two handshaked output channels, with per-channel delivered-word counters.

Parameters:
- DATA_W, 8, data word width.
- CNT_W, 16, width of the per-channel delivered-word counters.
- TIMEOUT, 8, stall cycles before a round-robin word is redirected (used only with DIST_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = round-robin, 1 = destination-directed; sampled only at word capture.
- in_valid  input  1  input word valid.
- in_ready  output  1  scheduler can accept a word this cycle.
- in_data  input  DATA_W  input word.
- in_dest  input  1  destination channel for mode=1; ignored in mode=0.
- out0_valid  output  1  channel 0 word valid.
- out0_ready  input  1  channel 0 accepts.
- out0_data  output  DATA_W  channel 0 word.
- out1_valid  output  1  channel 1 word valid.
- out1_ready  input  1  channel 1 accepts.
- out1_data  output  DATA_W  channel 1 word.
- dist_enable  output  1  distributor enable; high while a word is held.
- dist_select  output  1  distributor select; equals the current target channel.
- cnt0  output  CNT_W  words delivered on channel 0, saturating.
- cnt1  output  CNT_W  words delivered on channel 1, saturating.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset clears state to IDLE, hold_reg=0, target=0, rr_ptr=0, cnt0=cnt1=0, wait_cnt=0. All outputs are 0 except in_ready, which is 1 in IDLE.
- State IDLE:
  - in_ready=1; all out*_valid=0; dist_enable=0; dist_select=0.
  - On in_valid: capture in_data into hold_reg and record mode as hold_mode.
  - target = in_dest if mode=1, else rr_ptr. Go to HOLD.
- State HOLD:
  - dist_enable=1; dist_select=target.
  - out<target>_valid=1 and out<target>_data=hold_reg.
  - The non-target channel has valid=0 and data=0.
- Transfer: in HOLD when out<target>_ready=1. On transfer:
  - cnt<target> increments, saturating at all-ones.
  - If hold_mode=0, rr_ptr = ~target; if hold_mode=1, rr_ptr is unchanged.
- Back-to-back: in HOLD, in_ready = out<target>_ready.
  - Transfer and in_valid in the same cycle: capture the new word and stay in HOLD. The new target uses the updated rr_ptr.
  - Transfer without in_valid: go to IDLE.
- Latency: word accepted in cycle N is presented valid in cycle N+1. Sustained throughput is 1 word/cycle when the targets are ready.
- No transfer: hold_reg, target and outputs stay stable; valid is never withdrawn before ready.
- mode changes while in HOLD do not affect the held word.
- rst asserted mid-HOLD discards the held word with no transfer counted. Outputs are at reset values in the cycle after rst is sampled high.
- The ready of the non-target channel is ignored.

Optional Feature:
- Macro: DIST_TIMEOUT_EN.
- Defined:
  - In HOLD with hold_mode=0, wait_cnt counts cycles where out<target>_ready=0.
  - When wait_cnt reaches TIMEOUT, target flips to the other channel and wait_cnt clears. From the next cycle the word is presented there.
  - On transfer, rr_ptr = ~(channel actually used) and wait_cnt clears.
  - hold_mode=1 words are never redirected and wait_cnt stays 0.
- Undefined: no wait_cnt logic; TIMEOUT is unused; HOLD waits indefinitely.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, in_ready=1, cnt0=cnt1=0.
- Round-robin streaming: mode=0, both readies=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> out0 gets 0x11,0x33 and out1 gets 0x22,0x44, one per cycle starting 1 cycle after accept; cnt0=2, cnt1=2; dist_select toggles 0,1,0,1.
- Directed with backpressure: mode=1, in_dest=1, data 0xA5, out1_ready=0 for 5 cycles then 1 -> out1_valid=1 with 0xA5 held stable, in_ready=0 during stall, cnt1=1 after, out0_valid never 1.
- Counter saturation: CNT_W=2, send 5 words to channel 0 -> cnt0 stays 3.
- Reset mid-operation: word 0x5A held with out0_ready=0, assert rst -> next cycle out0_valid=0, cnt0 unchanged at 0, state IDLE.
- With DIST_TIMEOUT_EN, TIMEOUT=4: mode=0, word 0x3C targeting ch0, out0_ready=0, out1_ready=1 -> after 4 stall cycles 0x3C delivered on out1, cnt1=1, next round-robin word targets ch0.

Source files
------------

// File: rtl/dist_scheduler.sv
// dist_scheduler: valid/ready sequencer for an 8-bit 1-to-2 distributor with a one-entry hold register, round-robin or directed routing, and saturating per-channel delivery counters.
// Optional stall-timeout redirect of round-robin words is enabled by defining DIST_TIMEOUT_EN.
module dist_scheduler #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dest,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              dist_enable,
    output logic              dist_select,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              target_q, target_d;
    logic              hold_mode_q, hold_mode_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              xfer, cap;
`ifdef DIST_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]     wait_q, wait_d;
`endif

    assign dist_enable = state_q == HOLD;
    assign dist_select = dist_enable & target_q;
    assign out0_valid  = dist_enable & ~target_q;
    assign out1_valid  = dist_select;
    assign out0_data   = out0_valid ? hold_q : '0;
    assign out1_data   = out1_valid ? hold_q : '0;
    assign xfer        = dist_enable & (target_q ? out1_ready : out0_ready);
    assign in_ready    = (state_q == IDLE) | xfer;
    assign cap         = in_valid & in_ready;
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;

    // Next state: count/advance on transfer, optional stall redirect, then capture (new target sees updated rr pointer).
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        target_d    = target_q;
        hold_mode_d = hold_mode_q;
        rr_d        = rr_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
`ifdef DIST_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        if (xfer) begin
            cnt0_d  = (!target_q && !(&cnt0_q)) ? cnt0_q + 1'b1 : cnt0_q;
            cnt1_d  = (target_q && !(&cnt1_q)) ? cnt1_q + 1'b1 : cnt1_q;
            rr_d    = hold_mode_q ? rr_q : ~target_q;
            state_d = IDLE;
`ifdef DIST_TIMEOUT_EN
            wait_d  = '0;
        end else if (dist_enable && !hold_mode_q) begin
            wait_d = wait_q + 1'b1;
            if (wait_d == WW'(TIMEOUT)) begin
                target_d = ~target_q;
                wait_d   = '0;
            end
`endif
        end
        if (cap) begin
            hold_d      = in_data;
            hold_mode_d = mode;
            target_d    = mode ? in_dest : rr_d;
            state_d     = HOLD;
        end
    end

    // State register with synchronous reset discarding any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            target_q    <= 1'b0;
            hold_mode_q <= 1'b0;
            rr_q        <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
`ifdef DIST_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            target_q    <= target_d;
            hold_mode_q <= hold_mode_d;
            rr_q        <= rr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
`ifdef DIST_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end
endmodule

// File: tb/tb_dist_scheduler.sv
// tb_dist_scheduler: scoreboard bench for dist_scheduler with directed scenarios and random traffic.
module tb_dist_scheduler;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0, in_valid = 1'b0, in_dest = 1'b0;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out0_valid, out1_valid, dist_enable, dist_select;
    logic [DW-1:0] out0_data, out1_data;
    logic [CW-1:0] cnt0, cnt1;

    int total = 0, bad = 0;
    logic [DW-1:0] q0[$], q1[$];
    logic          rr_m = 1'b0;
    logic          dst;
    int            exp0 = 0, exp1 = 0;
    logic          pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
    logic [DW-1:0] pd0 = '0, pd1 = '0;

    dist_scheduler #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .dist_enable(dist_enable), .dist_select(dist_select), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted word is routed by the routing rule and queued for its channel.
    always @(negedge clk) begin
        if (rst) rr_m = 1'b0;
        else if (in_valid && in_ready) begin
            dst = mode ? in_dest : rr_m;
            if (!mode) rr_m = ~rr_m;
            if (dst) q1.push_back(in_data);
            else q0.push_back(in_data);
        end
    end

    // Monitor: checks delivered words, counters and handshake rules whenever the DUT presents data.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            exp0 = 0;
            exp1 = 0;
            pv0 = 0;
            pv1 = 0;
        end else begin
            chk("cnt0", 32'(cnt0), exp0);
            chk("cnt1", 32'(cnt1), exp1);
            chk("one_valid", 32'(out0_valid & out1_valid), 0);
            chk("enable", 32'(dist_enable), 32'(out0_valid | out1_valid));
            chk("select", 32'(dist_select), 32'(out1_valid));
            if (!out0_valid) chk("idle_data0", 32'(out0_data), 0);
            if (!out1_valid) chk("idle_data1", 32'(out1_data), 0);
            if (pv0 && !pr0) begin
                chk("stable_v0", 32'(out0_valid), 1);
                chk("stable_d0", 32'(out0_data), 32'(pd0));
            end
            if (pv1 && !pr1) begin
                chk("stable_v1", 32'(out1_valid), 1);
                chk("stable_d1", 32'(out1_data), 32'(pd1));
            end
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) chk("q0_underflow", 1, 0);
                else chk("data0", 32'(out0_data), 32'(q0.pop_front()));
                if (exp0 < (1 << CW) - 1) exp0++;
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) chk("q1_underflow", 1, 0);
                else chk("data1", 32'(out1_data), 32'(q1.pop_front()));
                if (exp1 < (1 << CW) - 1) exp1++;
            end
            pv0 = out0_valid; pr0 = out0_ready; pd0 = out0_data;
            pv1 = out1_valid; pr1 = out1_ready; pd1 = out1_data;
        end
    end

    initial begin
        logic [DW-1:0] rr_bytes[4];
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_valids", 32'({out0_valid, out1_valid, dist_enable, dist_select}), 0);
        chk("rst_cnts", 32'({cnt0, cnt1}), 0);
        rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = rr_bytes[i];
            step();
            chk("rr_select", 32'(dist_select), 32'(i & 1));
            chk("rr_data", 32'(i[0] ? out1_data : out0_data), 32'(rr_bytes[i]));
        end
        in_valid = 1'b0;
        step();
        chk("rr_cnt0", 32'(cnt0), 2);
        chk("rr_cnt1", 32'(cnt1), 2);

        mode = 1'b1; in_dest = 1'b1; in_data = 8'hA5; in_valid = 1'b1; out1_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid1", 32'(out1_valid), 1);
            chk("bp_data1", 32'(out1_data), 32'hA5);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid0", 32'(out0_valid), 0);
            step();
        end
        out1_ready = 1'b1;
        step();
        chk("bp_cnt1", 32'(cnt1), 3);

        mode = 1'b0; in_data = 8'h5A; in_valid = 1'b1; out0_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("mid_valid0", 32'(out0_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid0", 32'(out0_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_cnt0", 32'(cnt0), 0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom);
`ifdef DIST_TIMEOUT_EN
            mode = 1'b1;
`else
            mode = 1'($urandom);
`endif
            in_dest = 1'($urandom);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (4) step();
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
